// File: rtl/tradeoff_sched_pkg.sv
// rtl/tradeoff_sched_pkg.sv - shared state encoding and default sizes for tradeoff_sched
package tradeoff_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_W_BITS      = 25;
    localparam int DEF_N_BITS      = 13;
    localparam int DEF_TIMEOUT_CYC = 8192;
    localparam int DEF_ID_W        = 2;
    localparam int LAT_W           = 16;

endpackage

// File: rtl/tradeoff_sched_rr_arbiter.sv
// rtl/tradeoff_sched_rr_arbiter.sv - round-robin pick of the first valid requester at or after rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            hit;
    logic [ID_W-1:0] idx;

    // Scan from rr_ptr upward with wrap; the first set request wins.
    always_comb begin
        hit       = 1'b0;
        idx       = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!hit && req[idx]) begin
                hit       = 1'b1;
                grant_idx = idx;
            end
        end
        grant = '0;
        if (grant_en && hit) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tradeoff_sched.sv
// rtl/tradeoff_sched.sv - round-robin scheduler around one Tradeoff engine with watchdog; option TRADEOFF_LATENCY_EN
module tradeoff_sched
    import tradeoff_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int W_BITS      = DEF_W_BITS,
    parameter int N_BITS      = DEF_N_BITS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int ID_W        = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*W_BITS-1:0] req_w,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [N_BITS-1:0]         rsp_n,
    output logic                      rsp_timeout,
    output logic                      eng_rst_n,
    output logic [W_BITS-1:0]         eng_w,
    input  logic                      eng_found,
    input  logic [N_BITS-1:0]         eng_n,
    output logic                      busy
`ifdef TRADEOFF_LATENCY_EN
    ,
    output logic [LAT_W-1:0]          rsp_cycles
`endif
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gid;
    logic [ID_W-1:0]   grant_idx;
    logic [CNT_W-1:0]  wdog;
`ifdef TRADEOFF_LATENCY_EN
    logic [LAT_W-1:0]  run_cnt;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_en  ((state == IDLE) && !rst),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // The engine restart is held low through reset and pulsed for the single LOAD cycle.
    assign eng_rst_n = !(rst || (state == LOAD));
    assign busy      = (state != IDLE);

    // Job sequencing: grant, restart engine, watch for found or watchdog expiry, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gid         <= '0;
            wdog        <= '0;
            eng_w       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_n       <= '0;
            rsp_timeout <= 1'b0;
`ifdef TRADEOFF_LATENCY_EN
            run_cnt     <= '0;
            rsp_cycles  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        eng_w  <= req_w[int'(grant_idx)*W_BITS +: W_BITS];
                        gid    <= grant_idx;
                        rr_ptr <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    wdog  <= '0;
`ifdef TRADEOFF_LATENCY_EN
                    run_cnt <= '0;
`endif
                    state <= RUN;
                end
                RUN: begin
`ifdef TRADEOFF_LATENCY_EN
                    if (run_cnt != {LAT_W{1'b1}}) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
`endif
                    // found is only looked at here, so a level left over from the last job is harmless
                    if (eng_found) begin
                        state <= SETTLE;
                    end else if (wdog == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_n       <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_id      <= gid;
                        rsp_valid   <= 1'b1;
`ifdef TRADEOFF_LATENCY_EN
                        rsp_cycles  <= (run_cnt != {LAT_W{1'b1}}) ? run_cnt + 1'b1 : run_cnt;
`endif
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                SETTLE: begin
                    rsp_n       <= eng_n;
                    rsp_timeout <= 1'b0;
                    rsp_id      <= gid;
                    rsp_valid   <= 1'b1;
`ifdef TRADEOFF_LATENCY_EN
                    rsp_cycles  <= run_cnt;
`endif
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tradeoff_sched.sv
// tb/tb_tradeoff_sched.sv - scoreboard bench for tradeoff_sched with an engine stub and reference model
module tb_tradeoff_sched;

    localparam int NR  = 4;
    localparam int WB  = 25;
    localparam int NB  = 13;
    localparam int TO  = 64;
    localparam int IDW = 2;

    typedef struct {
        logic [WB-1:0] w;
        int            d;
    } job_t;

    typedef struct {
        int            id;
        logic [NB-1:0] n;
        bit            tmo;
        int            lat;
        int            acc;
        int            cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR*WB-1:0]     req_w;
    logic [NR-1:0]        req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [NB-1:0]        rsp_n;
    logic                 rsp_timeout;
    logic                 eng_rst_n;
    logic [WB-1:0]        eng_w;
    logic                 eng_found;
    logic [NB-1:0]        eng_n;
    logic                 busy;
`ifdef TRADEOFF_LATENCY_EN
    logic [15:0]          rsp_cycles;
`endif

    int checks = 0;
    int passes = 0;
    int ncyc   = 0;

    job_t          jq[NR][$];
    exp_t          eq[$];
    logic [WB-1:0] cw[NR];
    int            cd[NR];
    int            acc_cnt[NR];
    int            seen_cnt[NR];
    int            mptr = 0;
    bit            midle = 1'b1;
    bit            bp_hold = 1'b0;
    int            stub_d = 0;

    logic [15:0]   sc;
    logic [WB-1:0] wl;
    int            sd;

    always #5 clk = ~clk;

    tradeoff_sched #(
        .NUM_REQ(NR), .W_BITS(WB), .N_BITS(NB), .TIMEOUT_CYC(TO), .ID_W(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_w(req_w), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_n(rsp_n),
        .rsp_timeout(rsp_timeout), .eng_rst_n(eng_rst_n), .eng_w(eng_w),
        .eng_found(eng_found), .eng_n(eng_n), .busy(busy)
`ifdef TRADEOFF_LATENCY_EN
        , .rsp_cycles(rsp_cycles)
`endif
    );

    function automatic logic [NB-1:0] fn(input logic [WB-1:0] w);
        return NB'((w ^ (w >> 12)) & 25'h1fff);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    endtask

    // Engine stub: restarts while eng_rst_n is low, raises found sd RUN cycles later and then keeps it high.
    assign eng_found = (sd != 0) && (int'(sc) + 1 >= sd);
    assign eng_n     = eng_found ? fn(wl) : '0;

    always @(posedge clk) begin
        if (!eng_rst_n) begin
            sc <= '0;
            wl <= eng_w;
            sd <= stub_d;
        end else if (sc != 16'hffff) begin
            sc <= sc + 1'b1;
        end
    end

    // Requester driver: after an accept, present the next queued job at once or drop valid.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = acc_cnt[i];
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && jq[i].size() > 0) begin
                job_t j;
                j = jq[i].pop_front();
                cw[i] = j.w;
                cd[i] = j.d;
                req_w[i*WB +: WB] = j.w;
                req_valid[i] = 1'b1;
            end
        end
    end

    // Response consumer: random readiness unless backpressure is being forced.
    always @(posedge clk) begin
        #1;
        rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: predicts grants and pushes expectations, pops and compares responses.
    always @(negedge clk) begin : mon
        int            g;
        int            idx;
        exp_t          e;
        bit            load_flag;
        bit            load_next;
        bit            cont;
        logic [IDW-1:0] h_id;
        logic [NB-1:0]  h_n;
        logic           h_t;
        ncyc++;
        if (rst) begin
            check("eng_rst_n_in_rst", eng_rst_n, 0);
            eq.delete();
            mptr = 0;
            midle = 1'b1;
            cont = 1'b0;
            load_flag = 1'b0;
        end else begin
            check("eng_rst_n", eng_rst_n, load_flag ? 0 : 1);
            check("busy", busy, midle ? 0 : 1);
            load_next = 1'b0;
            g = -1;
            if (midle) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (mptr + k) % NR;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                e.id = g;
                e.acc = ncyc;
                if (cd[g] >= 1 && cd[g] <= TO) begin
                    e.tmo = 1'b0; e.n = fn(cw[g]); e.lat = 3 + cd[g]; e.cyc = cd[g];
                end else begin
                    e.tmo = 1'b1; e.n = '0; e.lat = 2 + TO; e.cyc = TO;
                end
                eq.push_back(e);
                stub_d = cd[g];
                acc_cnt[g]++;
                mptr = (g + 1) % NR;
                midle = 1'b0;
                load_next = 1'b1;
            end
            if (rsp_valid) begin
                if (!cont) begin
                    if (eq.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_n", rsp_n, e.n);
                        check("rsp_timeout", rsp_timeout, e.tmo);
                        check("latency", ncyc - e.acc, e.lat);
`ifdef TRADEOFF_LATENCY_EN
                        check("rsp_cycles", rsp_cycles, e.cyc);
`endif
                    end
                    h_id = rsp_id; h_n = rsp_n; h_t = rsp_timeout;
                end else begin
                    check("hold_id", rsp_id, h_id);
                    check("hold_n", rsp_n, h_n);
                    check("hold_timeout", rsp_timeout, h_t);
                end
                if (rsp_ready) midle = 1'b1;
            end
            cont = rsp_valid && !rsp_ready;
            load_flag = load_next;
        end
    end

    function automatic bit all_done();
        for (int i = 0; i < NR; i++) if (jq[i].size() != 0) return 1'b0;
        return (req_valid == '0) && (eq.size() == 0) && midle && !rsp_valid;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && !all_done()) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input int r, input logic [WB-1:0] w, input int d);
        job_t j;
        j.w = w;
        j.d = d;
        jq[r].push_back(j);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_w = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cw[i] = '0; cd[i] = 0; acc_cnt[i] = 0; seen_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_n", rsp_n, 0);
        check("reset_rsp_timeout", rsp_timeout, 0);
        check("reset_eng_w", eng_w, 0);
        check("reset_busy", busy, 0);

        // single requester, all-ones operand
        push(0, 25'h1ffffff, 10);
        wait_idle("wait_single", 500);

        // all four requesters, plus a second job on requester 0
        push(0, 100, 3); push(1, 200, 3); push(2, 300, 3); push(3, 400, 3); push(0, 500, 1);
        wait_idle("wait_rr", 1000);

        // watchdog: never found, found exactly on the last cycle, one cycle too late
        push(1, 25'h0abcde, 0); push(2, 25'h012345, 7); push(3, 25'h1f0f0f, TO); push(0, 25'h0f0f0f, TO + 1);
        wait_idle("wait_timeout", 1500);

        // backpressure held for 20 cycles with a second request waiting
        bp_hold = 1'b1;
        push(0, 25'h155555, 2); push(1, 25'h0aaaaa, 4);
        n = 0;
        while (n < 200 && !rsp_valid) begin @(negedge clk); n++; end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (20) @(negedge clk);
        check("bp_still_valid", rsp_valid, 1);
        bp_hold = 1'b0;
        wait_idle("wait_bp", 500);

        // reset during RUN cycle 5
        push(2, 25'h0123ab, 30);
        n = 0;
        while (n < 200 && midle) begin @(negedge clk); n++; end
        check("rst_job_accepted", midle, 0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("busy_after_rst", busy, 0);
        check("rsp_valid_after_rst", rsp_valid, 0);
        push(2, 25'h0123ab, 5);
        wait_idle("wait_rst", 500);

        // back-to-back jobs on one requester: found stays high into the next LOAD
        push(3, 25'h000777, 2); push(3, 25'h1c0de0, 5); push(3, 25'h000001, 1);
        wait_idle("wait_stale", 500);

        // randomized mix
        for (int k = 0; k < 40; k++) begin
            push(int'($urandom_range(0, NR - 1)), WB'($urandom), int'($urandom_range(0, TO + 6)));
        end
        wait_idle("wait_random", 20000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
